// File: rtl/SB_codex_pkg.sv
// Shared sideband types: message codes, arbiter FSM states and the idle message value.
package SB_codex_pkg;

  typedef enum logic [7:0] {
    SB_MSG_NONE               = 8'h00,
    LinkMgmt_RDI_Active_req   = 8'h01,
    LinkMgmt_RDI_Active_rsp   = 8'h02,
    SBINIT_out_of_reset       = 8'h10,
    SBINIT_done_req           = 8'h11,
    SBINIT_done_rsp           = 8'h12,
    MBINIT_PARAM_config_req   = 8'h20,
    MBINIT_PARAM_config_rsp   = 8'h21,
    MBTRAIN_VALVREF_start_req = 8'h30,
    MBTRAIN_VALVREF_end_req   = 8'h31,
    LINKINIT_done_req         = 8'h40
  } SB_msg_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BUSY  = 2'd1,
    WAIT_READY = 2'd2
  } sb_arb_state_t;

  localparam int unsigned SB_DATA_W = 64;

  function automatic SB_msg_t reset_SB_msg();
    return SB_MSG_NONE;
  endfunction

endpackage

// File: rtl/sb_rr_pick.sv
// Round-robin winner search: first pending index starting at rr_ptr_i, wrapping modulo NUM_REQ.
module sb_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         pending_i,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
  output logic                       any_pending_o,
  output logic [$clog2(NUM_REQ)-1:0] winner_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0]   sum_s;
  logic             hit_s;
  logic             found_s;
  logic [IDX_W-1:0] winner_s;

  // Walk the offsets in priority order and latch the first pending hit
  always_comb begin
    sum_s    = '0;
    hit_s    = 1'b0;
    found_s  = 1'b0;
    winner_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s    = {1'b0, rr_ptr_i} + (IDX_W+1)'(k);
      sum_s    = (sum_s >= NUM_REQ_W) ? (sum_s - NUM_REQ_W) : sum_s;
      hit_s    = !found_s && pending_i[sum_s[IDX_W-1:0]];
      winner_s = hit_s ? sum_s[IDX_W-1:0] : winner_s;
      found_s  = found_s | hit_s;
    end
  end

  assign any_pending_o = |pending_i;
  assign winner_o      = winner_s;

endmodule

// File: rtl/sb_tx_arbiter.sv
// Sideband TX arbiter: one-entry slot per LTSM requester, round-robin issue to the SB TX serializer
// paced by the serializer's sendNextFlag handshake.
module sb_tx_arbiter
  import SB_codex_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int BUSY_WAIT_MAX = 4
) (
  input  logic                         clk_100MHz,
  input  logic                         reset_n,
  input  SB_msg_t                      req_msg_i  [NUM_REQ],
  input  logic [SB_DATA_W-1:0]         req_data_i [NUM_REQ],
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ-1:0]           req_flush_i,
  output logic [NUM_REQ-1:0]           req_pending_o,
  output logic [NUM_REQ-1:0]           req_sent_o,
  output logic [NUM_REQ-1:0]           req_overwrite_o,
  output logic [$clog2(NUM_REQ)-1:0]   grant_idx_o,
  output SB_msg_t                      SB_TX_msg_o,
  output logic [SB_DATA_W-1:0]         SB_TX_dataBus_o,
  output logic                         SB_TX_msg_valid_o,
  input  logic                         SB_TX_msg_sendNextFlag_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (BUSY_WAIT_MAX > 1) ? $clog2(BUSY_WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BUSY_WAIT_MAX - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  SB_msg_t              slot_msg_r  [NUM_REQ];
  logic [SB_DATA_W-1:0] slot_data_r [NUM_REQ];
  logic [NUM_REQ-1:0]   pending_r;
  logic [NUM_REQ-1:0]   sent_r;
  logic [NUM_REQ-1:0]   overwrite_r;
  logic [IDX_W-1:0]     rr_ptr_r;
  logic [IDX_W-1:0]     grant_r;
  SB_msg_t              tx_msg_r;
  logic [SB_DATA_W-1:0] tx_data_r;
  logic                 tx_valid_r;
  sb_arb_state_t        state_r;
  logic [CNT_W-1:0]     cnt_r;

  logic                 any_pending_s;
  logic [IDX_W-1:0]     winner_s;
  logic                 issue_s;
  logic [NUM_REQ-1:0]   issue_vec_s;
  logic [NUM_REQ-1:0]   pending_nxt_s;
  logic [NUM_REQ-1:0]   overwrite_nxt_s;
  logic [IDX_W-1:0]     rr_ptr_nxt_s;
  sb_arb_state_t        state_nxt_s;
  logic [CNT_W-1:0]     cnt_nxt_s;

  sb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .pending_i     (pending_r),
    .rr_ptr_i      (rr_ptr_r),
    .any_pending_o (any_pending_s),
    .winner_o      (winner_s)
  );

  // Issue decision and slot bookkeeping; a capture on the slot being issued keeps the new content pending
  always_comb begin
    issue_s         = (state_r == IDLE) && any_pending_s && SB_TX_msg_sendNextFlag_i;
    issue_vec_s     = issue_s ? (ONE_HOT0 << winner_s) : '0;
    pending_nxt_s   = req_valid_i | (pending_r & ~req_flush_i & ~issue_vec_s);
    overwrite_nxt_s = req_valid_i & pending_r & ~issue_vec_s;
    rr_ptr_nxt_s    = (winner_s == IDX_LAST) ? '0 : (winner_s + IDX_ONE);
  end

  // Handshake FSM: after an issue, wait for the serializer to go busy then ready, or time out
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (issue_s) begin
          state_nxt_s = WAIT_BUSY;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (!SB_TX_msg_sendNextFlag_i) begin
          state_nxt_s = WAIT_READY;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      WAIT_READY: begin
        if (SB_TX_msg_sendNextFlag_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_READY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Slot storage: content only, pending flags live with the control state
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_msg_r[i]  <= reset_SB_msg();
        slot_data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid_i[i]) begin
          slot_msg_r[i]  <= req_msg_i[i];
          slot_data_r[i] <= req_data_i[i];
        end
      end
    end
  end

  // Control state and registered serializer outputs; message/data hold between strobes
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      pending_r   <= '0;
      sent_r      <= '0;
      overwrite_r <= '0;
      rr_ptr_r    <= '0;
      grant_r     <= '0;
      tx_msg_r    <= reset_SB_msg();
      tx_data_r   <= '0;
      tx_valid_r  <= 1'b0;
      state_r     <= IDLE;
      cnt_r       <= '0;
    end else begin
      pending_r   <= pending_nxt_s;
      sent_r      <= issue_vec_s;
      overwrite_r <= overwrite_nxt_s;
      tx_valid_r  <= issue_s;
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      if (issue_s) begin
        tx_msg_r  <= slot_msg_r[winner_s];
        tx_data_r <= slot_data_r[winner_s];
        grant_r   <= winner_s;
        rr_ptr_r  <= rr_ptr_nxt_s;
      end
    end
  end

  assign req_pending_o     = pending_r;
  assign req_sent_o        = sent_r;
  assign req_overwrite_o   = overwrite_r;
  assign grant_idx_o       = grant_r;
  assign SB_TX_msg_o       = tx_msg_r;
  assign SB_TX_dataBus_o   = tx_data_r;
  assign SB_TX_msg_valid_o = tx_valid_r;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed self-checking bench for sb_tx_arbiter (NUM_REQ = 4, BUSY_WAIT_MAX = 4).
module tb_sb_tx_arbiter;
  import SB_codex_pkg::*;

  localparam int NUM_REQ = 4;

  logic          clk_100MHz = 1'b0;
  logic          reset_n;
  SB_msg_t       req_msg  [NUM_REQ];
  logic [63:0]   req_data [NUM_REQ];
  logic [3:0]    req_valid;
  logic [3:0]    req_flush;
  logic [3:0]    req_pending;
  logic [3:0]    req_sent;
  logic [3:0]    req_overwrite;
  logic [1:0]    grant_idx;
  SB_msg_t       tx_msg;
  logic [63:0]   tx_data;
  logic          tx_valid;
  logic          flag;

  int checks   = 0;
  int failures = 0;

  sb_tx_arbiter #(
    .NUM_REQ       (4),
    .BUSY_WAIT_MAX (4)
  ) dut (
    .clk_100MHz               (clk_100MHz),
    .reset_n                  (reset_n),
    .req_msg_i                (req_msg),
    .req_data_i               (req_data),
    .req_valid_i              (req_valid),
    .req_flush_i              (req_flush),
    .req_pending_o            (req_pending),
    .req_sent_o               (req_sent),
    .req_overwrite_o          (req_overwrite),
    .grant_idx_o              (grant_idx),
    .SB_TX_msg_o              (tx_msg),
    .SB_TX_dataBus_o          (tx_data),
    .SB_TX_msg_valid_o        (tx_valid),
    .SB_TX_msg_sendNextFlag_i (flag)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input int w, input SB_msg_t m, input logic [63:0] d);
    chk({tag, ".valid"}, 64'(tx_valid), 64'h1);
    chk({tag, ".msg"},   64'(tx_msg),   64'(m));
    chk({tag, ".data"},  tx_data,       d);
    chk({tag, ".sent"},  64'(req_sent), 64'h1 << w);
    chk({tag, ".grant"}, 64'(grant_idx), 64'(w));
  endtask

  // Serializer goes busy then ready again; optional captures ride on the first edge
  task automatic bounce(input logic [3:0] mask);
    flag      = 1'b0;
    req_valid = mask;
    tick();
    req_valid = 4'b0000;
    chk("bounce.busy_novalid", 64'(tx_valid), 64'h0);
    flag = 1'b1;
    tick();
    chk("bounce.ready_novalid", 64'(tx_valid), 64'h0);
    tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 4'b0000;
    req_flush = 4'b0000;
    flag      = 1'b1;
    req_msg[0] = MBINIT_PARAM_config_req;   req_data[0] = 64'hD0D0_0000_0000_0010;
    req_msg[1] = MBTRAIN_VALVREF_start_req; req_data[1] = 64'hD0D0_0000_0000_0011;
    req_msg[2] = LinkMgmt_RDI_Active_req;   req_data[2] = 64'hA5A5_0000_1234_0002;
    req_msg[3] = SBINIT_done_req;           req_data[3] = 64'hD0D0_0000_0000_0013;
    tick();
    tick();
    chk("rst.pending",   64'(req_pending),   64'h0);
    chk("rst.sent",      64'(req_sent),      64'h0);
    chk("rst.overwrite", 64'(req_overwrite), 64'h0);
    chk("rst.grant",     64'(grant_idx),     64'h0);
    chk("rst.msg",       64'(tx_msg),        64'(SB_MSG_NONE));
    chk("rst.data",      tx_data,            64'h0);
    chk("rst.valid",     64'(tx_valid),      64'h0);
    reset_n = 1'b1;
    tick();

    // Single request from req 2, two-cycle capture-to-strobe latency
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    chk("single.pending", 64'(req_pending), 64'h4);
    chk("single.novalid", 64'(tx_valid),    64'h0);
    tick();
    chk_issue("single", 2, LinkMgmt_RDI_Active_req, 64'hA5A5_0000_1234_0002);
    chk("single.cleared", 64'(req_pending), 64'h0);
    flag      = 1'b0;
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    chk("toggle.novalid0", 64'(tx_valid),    64'h0);
    chk("toggle.sent0",    64'(req_sent),    64'h0);
    chk("toggle.pending",  64'(req_pending), 64'h8);
    flag = 1'b1;
    tick();
    chk("toggle.novalid1", 64'(tx_valid), 64'h0);
    tick();
    chk_issue("toggle.req3", 3, SBINIT_done_req, 64'hD0D0_0000_0000_0013);

    // Busy timeout: flag stays high, four quiet cycles, then the next issue
    req_valid = 4'b1011;
    tick();
    req_valid = 4'b0000;
    chk("timeout.pending", 64'(req_pending), 64'hB);
    chk("timeout.q1", 64'(tx_valid), 64'h0);
    tick();
    chk("timeout.q2", 64'(tx_valid), 64'h0);
    tick();
    chk("timeout.q3", 64'(tx_valid), 64'h0);
    tick();
    chk("timeout.q4", 64'(tx_valid), 64'h0);
    tick();
    chk_issue("rr.first0", 0, MBINIT_PARAM_config_req, 64'hD0D0_0000_0000_0010);
    chk("rr.pend_after0", 64'(req_pending), 64'hA);

    // Round-robin order 0,1,3 then 0,1 from rr_ptr 0 and 0,1 from rr_ptr 2
    bounce(4'b0000);
    chk_issue("rr.first1", 1, MBTRAIN_VALVREF_start_req, 64'hD0D0_0000_0000_0011);
    bounce(4'b0000);
    chk_issue("rr.first3", 3, SBINIT_done_req, 64'hD0D0_0000_0000_0013);
    bounce(4'b0011);
    chk_issue("rr.second0", 0, MBINIT_PARAM_config_req, 64'hD0D0_0000_0000_0010);
    bounce(4'b0000);
    chk_issue("rr.second1", 1, MBTRAIN_VALVREF_start_req, 64'hD0D0_0000_0000_0011);
    bounce(4'b0011);
    chk_issue("rr.wrap0", 0, MBINIT_PARAM_config_req, 64'hD0D0_0000_0000_0010);
    bounce(4'b0000);
    chk_issue("rr.wrap1", 1, MBTRAIN_VALVREF_start_req, 64'hD0D0_0000_0000_0011);

    // Overwrite of req 1 while the serializer is busy
    flag = 1'b0;
    tick();
    req_msg[1] = LINKINIT_done_req;        req_data[1] = 64'h0000_0000_AAAA_AAAA;
    req_valid  = 4'b0010;
    tick();
    chk("ovw.first_pending", 64'(req_pending),   64'h2);
    chk("ovw.first_nopulse", 64'(req_overwrite), 64'h0);
    req_msg[1] = MBTRAIN_VALVREF_end_req;  req_data[1] = 64'h0000_0000_BBBB_BBBB;
    tick();
    req_valid = 4'b0000;
    chk("ovw.pulse",   64'(req_overwrite), 64'h2);
    chk("ovw.pending", 64'(req_pending),   64'h2);
    tick();
    chk("ovw.pulse_end", 64'(req_overwrite), 64'h0);
    flag = 1'b1;
    tick();
    chk("ovw.novalid", 64'(tx_valid), 64'h0);
    tick();
    chk_issue("ovw.issueB", 1, MBTRAIN_VALVREF_end_req, 64'h0000_0000_BBBB_BBBB);
    bounce(4'b0000);
    chk("ovw.once_valid",   64'(tx_valid),    64'h0);
    chk("ovw.once_pending", 64'(req_pending), 64'h0);

    // Flush alone, then flush with valid in the same cycle
    flag       = 1'b0;
    req_msg[0] = MBINIT_PARAM_config_rsp;  req_data[0] = 64'hCCCC_CCCC_0000_0000;
    req_valid  = 4'b0001;
    tick();
    req_valid = 4'b0000;
    chk("flush.loaded", 64'(req_pending), 64'h1);
    req_flush = 4'b0001;
    tick();
    req_flush = 4'b0000;
    chk("flush.cleared", 64'(req_pending), 64'h0);
    flag = 1'b1;
    tick();
    tick();
    chk("flush.noissue", 64'(tx_valid), 64'h0);
    req_valid = 4'b0001;
    req_flush = 4'b0001;
    tick();
    req_flush = 4'b0000;
    chk("flushvalid.pending", 64'(req_pending), 64'h1);
    chk("flushvalid.novalid", 64'(tx_valid),    64'h0);
    // Capture on the slot being issued: old content goes out, new stays pending
    req_msg[0] = LinkMgmt_RDI_Active_rsp;  req_data[0] = 64'hDDDD_DDDD_0000_0000;
    tick();
    req_valid = 4'b0000;
    chk_issue("flushvalid.issue", 0, MBINIT_PARAM_config_rsp, 64'hCCCC_CCCC_0000_0000);
    chk("sameissue.pending",   64'(req_pending),   64'h1);
    chk("sameissue.noovw",     64'(req_overwrite), 64'h0);

    // Async reset in WAIT_READY with three slots pending
    flag      = 1'b0;
    req_valid = 4'b0110;
    tick();
    req_valid = 4'b0000;
    chk("arst.pre_pending", 64'(req_pending), 64'h7);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst.pending", 64'(req_pending), 64'h0);
    chk("arst.msg",     64'(tx_msg),      64'(SB_MSG_NONE));
    chk("arst.data",    tx_data,          64'h0);
    chk("arst.grant",   64'(grant_idx),   64'h0);
    chk("arst.valid",   64'(tx_valid),    64'h0);
    chk("arst.sent",    64'(req_sent),    64'h0);
    flag = 1'b1;
    #2;
    reset_n = 1'b1;
    tick();
    chk("arst.quiet1", 64'(tx_valid), 64'h0);
    tick();
    chk("arst.quiet2", 64'(tx_valid), 64'h0);
    tick();
    chk("arst.quiet3",   64'(tx_valid),    64'h0);
    chk("arst.nopend",   64'(req_pending), 64'h0);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    chk("arst.new_novalid", 64'(tx_valid), 64'h0);
    tick();
    chk_issue("arst.new", 2, LinkMgmt_RDI_Active_req, 64'hA5A5_0000_1234_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
